// File: rtl/tap_bram_arbiter.sv
// Single-port tap BRAM arbiter: FIR engine tap reads have fixed priority, AXI-Lite
// config reads get a starvation-guard slot, AXI writes wait while the engine is busy.
module tap_bram_arbiter #(
  parameter int pDATA_WIDTH   = 32,
  parameter int TAP_NUM_WIDTH = 10,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       engine_busy,
  input  logic                       s_arvalid,
  input  logic                       s_awvalid,
  input  logic                       s_wvalid,
  input  logic                       s_rready,
  output logic                       arbit_arready,
  output logic                       arbit_awready,
  output logic                       arbit_wready,
  output logic                       arbit_rvalid,
  input  logic [TAP_NUM_WIDTH-1:0]   slv_A,
  input  logic                       slv_EN,
  input  logic [pDATA_WIDTH/8-1:0]   slv_WE,
  input  logic [pDATA_WIDTH-1:0]     slv_Di,
  output logic [pDATA_WIDTH-1:0]     slv_Do,
  input  logic                       eng_req,
  input  logic [TAP_NUM_WIDTH-1:0]   eng_A,
  output logic                       eng_gnt,
  output logic                       eng_rvalid,
  output logic [pDATA_WIDTH-1:0]     eng_Do,
  output logic [TAP_NUM_WIDTH-1:0]   tap_A,
  output logic                       tap_EN,
  output logic [pDATA_WIDTH/8-1:0]   tap_WE,
  output logic [pDATA_WIDTH-1:0]     tap_Di,
  input  logic [pDATA_WIDTH-1:0]     tap_Do
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_CAP, RD_HOLD, WR} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       starve_q, starve_d;
  logic                   last_wr_q, last_wr_d;
  logic [pDATA_WIDTH-1:0] slv_do_q, slv_do_d;
  logic                   eng_rvalid_q;

  logic in_idle, starve_full, eng_win, ar_ok, aw_ok, ar_sel, aw_sel;
  logic ar_hsk, aw_hsk, w_hsk, eng_gnt_c;

  // Grant decode; every handshake is masked during reset so the BRAM sees no
  // access and the slave sees no ready in the reset cycle.
  assign in_idle     = (state_q == IDLE);
  assign starve_full = s_arvalid && (starve_q == STARVE_MAX);
  assign eng_win     = in_idle && eng_req && !starve_full;
  assign ar_ok       = s_arvalid;
  assign aw_ok       = s_awvalid && !engine_busy;
  assign ar_sel      = ar_ok && (!aw_ok || last_wr_q);
  assign aw_sel      = aw_ok && !ar_sel;
  assign ar_hsk      = !areset && in_idle && !eng_win && ar_sel;
  assign aw_hsk      = !areset && in_idle && !eng_win && aw_sel;
  assign w_hsk       = !areset && (state_q == WR) && s_wvalid;
  assign eng_gnt_c   = !areset && eng_req &&
                       (eng_win || state_q == RD_CAP || state_q == RD_HOLD);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      last_wr_q    <= 1'b0;
      slv_do_q     <= '0;
      eng_rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      starve_q     <= starve_d;
      last_wr_q    <= last_wr_d;
      slv_do_q     <= slv_do_d;
      eng_rvalid_q <= eng_gnt_c;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a
    // latch would be inferred to hold the missing values.
    state_d   = state_q;
    last_wr_d = last_wr_q;
    slv_do_d  = slv_do_q;
    starve_d  = starve_q;
    case (state_q)
      IDLE: begin
        if (ar_hsk) begin
          state_d   = RD_CAP;
          last_wr_d = 1'b0;
        end else if (aw_hsk) begin
          state_d   = WR;
          last_wr_d = 1'b1;
        end
      end
      RD_CAP: begin
        slv_do_d = tap_Do;
        state_d  = RD_HOLD;
      end
      RD_HOLD: if (s_rready) state_d = IDLE;
      WR:      if (s_wvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!s_arvalid || ar_hsk) begin
      starve_d = '0;
    end else if (in_idle && starve_q != STARVE_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    arbit_arready = ar_hsk;
    arbit_awready = aw_hsk;
    arbit_wready  = !areset && (state_q == WR);
    arbit_rvalid  = !areset && (state_q == RD_HOLD);
    eng_gnt       = eng_gnt_c;
    tap_A         = '0;
    tap_EN        = 1'b0;
    tap_WE        = '0;
    tap_Di        = '0;
    // The slave's EN only reaches the BRAM in its AR and W handshake cycles.
    if (eng_gnt_c) begin
      tap_A  = eng_A;
      tap_EN = 1'b1;
    end else if (ar_hsk) begin
      tap_A  = slv_A;
      tap_EN = slv_EN;
    end else if (w_hsk) begin
      tap_A  = slv_A;
      tap_EN = slv_EN;
      tap_WE = slv_WE;
      tap_Di = slv_Di;
    end
  end

  assign slv_Do     = slv_do_q;
  assign eng_rvalid = eng_rvalid_q;
  assign eng_Do     = tap_Do;

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Bench for tap_bram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the grant rules and a shadow tap memory.
module tb_tap_bram_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int WEW = DW / 8;
  localparam int SL  = 8;

  logic           aclk = 1'b0;
  logic           areset;
  logic           engine_busy, s_arvalid, s_awvalid, s_wvalid, s_rready;
  logic           arbit_arready, arbit_awready, arbit_wready, arbit_rvalid;
  logic [AW-1:0]  slv_A, eng_A, tap_A;
  logic           slv_EN, eng_req, eng_gnt, eng_rvalid, tap_EN;
  logic [WEW-1:0] slv_WE, tap_WE;
  logic [DW-1:0]  slv_Di, slv_Do, eng_Do, tap_Di, tap_Do;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always #5 aclk = ~aclk;

  tap_bram_arbiter #(.pDATA_WIDTH(DW), .TAP_NUM_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .aclk(aclk), .areset(areset), .engine_busy(engine_busy),
    .s_arvalid(s_arvalid), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_rready(s_rready),
    .arbit_arready(arbit_arready), .arbit_awready(arbit_awready),
    .arbit_wready(arbit_wready), .arbit_rvalid(arbit_rvalid),
    .slv_A(slv_A), .slv_EN(slv_EN), .slv_WE(slv_WE), .slv_Di(slv_Di), .slv_Do(slv_Do),
    .eng_req(eng_req), .eng_A(eng_A), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_Do(eng_Do),
    .tap_A(tap_A), .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_Di(tap_Di), .tap_Do(tap_Do)
  );

  // Single-port BRAM, read-old, one-cycle read latency.
  always @(posedge aclk) begin
    if (tap_EN) begin
      for (int b = 0; b < WEW; b++)
        if (tap_WE[b]) mem[tap_A][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= mem[tap_A];
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic clear_inputs();
    engine_busy = 0; s_arvalid = 0; s_awvalid = 0; s_wvalid = 0; s_rready = 0;
    slv_A = '0; slv_EN = 0; slv_WE = '0; slv_Di = '0; eng_req = 0; eng_A = '0;
  endtask

  // Drives one W beat in the WR state and records the write in the shadow memory.
  task automatic wr_data_phase(input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_wvalid = 1; slv_A = a; slv_EN = 1; slv_WE = '1; slv_Di = d;
    step();
    s_wvalid = 0; slv_EN = 0; slv_WE = '0; slv_Di = '0;
    shadow[a] = d;
  endtask

  // Called in the capture cycle; returns rvalid and data seen at the R handshake.
  task automatic rd_data_phase(output logic v, output logic [DW-1:0] got);
    step();
    s_rready = 1;
    sample();
    v = arbit_rvalid;
    got = slv_Do;
    step();
    s_rready = 0;
  endtask

  task automatic test_reset();
    areset = 1; s_awvalid = 1; s_arvalid = 1; s_wvalid = 1; eng_req = 1; s_rready = 1;
    slv_A = 3; eng_A = 4; slv_EN = 1; slv_WE = '1; slv_Di = 32'hDEAD_BEEF;
    step();
    sample();
    checks++;
    if ({arbit_arready, arbit_awready, arbit_wready, arbit_rvalid, eng_gnt, eng_rvalid, tap_EN, tap_WE} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got ar=%0b aw=%0b w=%0b rv=%0b gnt=%0b erv=%0b en=%0b we=%h required all 0",
               arbit_arready, arbit_awready, arbit_wready, arbit_rvalid, eng_gnt, eng_rvalid, tap_EN, tap_WE);
    end
    checks++;
    if ({tap_A, tap_Di, slv_Do} !== '0) begin
      failures++;
      $display("FAIL reset_data got tap_A=%h tap_Di=%h slv_Do=%h required 0", tap_A, tap_Di, slv_Do);
    end
    clear_inputs();
    areset = 0;
    step();
  endtask

  task automatic test_write();
    s_awvalid = 1; slv_A = 2; slv_EN = 0;
    sample();
    checks++;
    if ({arbit_awready, arbit_arready, tap_EN} !== 3'b100) begin
      failures++;
      $display("FAIL write_aw got aw=%0b ar=%0b en=%0b required aw=1 ar=0 en=0", arbit_awready, arbit_arready, tap_EN);
    end
    step();
    s_awvalid = 0; s_wvalid = 1; slv_A = 2; slv_EN = 1; slv_WE = 4'hF; slv_Di = 32'h5;
    sample();
    checks++;
    if ({arbit_wready, tap_EN, tap_A, tap_WE, tap_Di} !== {1'b1, 1'b1, 10'd2, 4'hF, 32'h5}) begin
      failures++;
      $display("FAIL write_w got wready=%0b en=%0b A=%0d WE=%h Di=%h required 1 1 2 f 5",
               arbit_wready, tap_EN, tap_A, tap_WE, tap_Di);
    end
    step();
    shadow[2] = 32'h5;
    s_wvalid = 0; slv_EN = 0; slv_WE = '0; slv_Di = '0;
    sample();
    checks++;
    if ({arbit_wready, tap_EN, tap_WE} !== '0) begin
      failures++;
      $display("FAIL write_done got wready=%0b en=%0b WE=%h required 0", arbit_wready, tap_EN, tap_WE);
    end
    step();
  endtask

  task automatic test_read();
    s_arvalid = 1; slv_A = 2; slv_EN = 1;
    sample();
    checks++;
    if ({arbit_arready, arbit_awready, tap_EN, tap_WE, tap_A} !== {1'b1, 1'b0, 1'b1, 4'h0, 10'd2}) begin
      failures++;
      $display("FAIL read_ar got ar=%0b aw=%0b en=%0b WE=%h A=%0d required 1 0 1 0 2",
               arbit_arready, arbit_awready, tap_EN, tap_WE, tap_A);
    end
    step();
    s_arvalid = 0;
    sample();
    checks++;
    if ({arbit_rvalid, tap_EN} !== 2'b00) begin
      failures++;
      $display("FAIL read_cap got rvalid=%0b en=%0b required 0 0 (slave EN ignored)", arbit_rvalid, tap_EN);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) s_rready = 1;
      sample();
      checks++;
      if (arbit_rvalid !== 1'b1 || slv_Do !== 32'h5) begin
        failures++;
        $display("FAIL read_hold%0d got rvalid=%0b data=%h required 1 5", i, arbit_rvalid, slv_Do);
      end
      step();
    end
    s_rready = 0; slv_EN = 0;
    sample();
    checks++;
    if (arbit_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_end got rvalid=%0b required 0", arbit_rvalid);
    end
    step();
  endtask

  task automatic test_alternate();
    logic          pref_write;
    logic          v;
    logic [DW-1:0] got;
    pref_write = 1;
    for (int it = 0; it < 4; it++) begin
      s_arvalid = 1; s_awvalid = 1; slv_A = 2; slv_EN = 1; slv_WE = '0;
      sample();
      checks++;
      if (arbit_awready !== pref_write || arbit_arready !== !pref_write) begin
        failures++;
        $display("FAIL alt_grant%0d got ar=%0b aw=%0b required aw=%0b", it, arbit_arready, arbit_awready, pref_write);
      end
      step();
      if (pref_write) begin
        s_awvalid = 0;
        wr_data_phase(AW'(6 + it), $urandom);
      end else begin
        s_arvalid = 0;
        rd_data_phase(v, got);
        checks++;
        if (v !== 1'b1 || got !== shadow[2]) begin
          failures++;
          $display("FAIL alt_rdata%0d got rvalid=%0b data=%h required 1 %h", it, v, got, shadow[2]);
        end
      end
      pref_write = !pref_write;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_starve();
    int            waits;
    logic          got_ar, eng_ok, v;
    logic [DW-1:0] got;
    engine_busy = 1; eng_req = 1; eng_A = 6; s_arvalid = 1; slv_A = 2; slv_EN = 1;
    waits = 0; got_ar = 0; eng_ok = 1;
    for (int i = 0; i < 3 * SL && !got_ar; i++) begin
      sample();
      if (arbit_arready) begin
        got_ar = 1;
      end else begin
        if (!eng_gnt || (i > 0 && (!eng_rvalid || eng_Do !== shadow[6]))) eng_ok = 0;
        waits++;
        step();
      end
    end
    checks++;
    if (!got_ar || waits != SL) begin
      failures++;
      $display("FAIL starve_waits got arready=%0b after %0d waits required 1 after %0d", got_ar, waits, SL);
    end
    checks++;
    if (eng_gnt !== 1'b0) begin
      failures++;
      $display("FAIL starve_gnt got eng_gnt=%0b in forced slot required 0", eng_gnt);
    end
    checks++;
    if (!eng_ok) begin
      failures++;
      $display("FAIL starve_engine got engine grant/data wrong while waiting required gnt=1 data=%h", shadow[6]);
    end
    step();
    s_arvalid = 0;
    sample();
    checks++;
    if ({eng_gnt, eng_rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL starve_cap got gnt=%0b erv=%0b required 1 0", eng_gnt, eng_rvalid);
    end
    rd_data_phase(v, got);
    checks++;
    if (v !== 1'b1 || got !== shadow[2]) begin
      failures++;
      $display("FAIL starve_rdata got rvalid=%0b data=%h required 1 %h", v, got, shadow[2]);
    end
    eng_req = 0; slv_EN = 0;
    step();
  endtask

  task automatic test_aw_blocked();
    logic          seen, v;
    logic [DW-1:0] got;
    engine_busy = 1; eng_req = 0; s_awvalid = 1; slv_EN = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (arbit_awready) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL busy_block got awready=1 while busy required 0");
    end
    engine_busy = 0;
    sample();
    checks++;
    if (arbit_awready !== 1'b1) begin
      failures++;
      $display("FAIL busy_release got awready=%0b required 1", arbit_awready);
    end
    step();
    s_awvalid = 0;
    wr_data_phase(9, 32'h1234_5678);
    s_arvalid = 1; slv_A = 9; slv_EN = 1;
    step();
    s_arvalid = 0;
    rd_data_phase(v, got);
    checks++;
    if (v !== 1'b1 || got !== 32'h1234_5678) begin
      failures++;
      $display("FAIL busy_readback got rvalid=%0b data=%h required 1 12345678", v, got);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_in_wr();
    logic          v;
    logic [DW-1:0] got;
    s_awvalid = 1;
    sample();
    checks++;
    if (arbit_awready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wr_aw got awready=%0b required 1", arbit_awready);
    end
    step();
    s_awvalid = 0; areset = 1;
    s_wvalid = 1; slv_A = 5; slv_EN = 1; slv_WE = '1; slv_Di = 32'hDEAD_BEEF;
    sample();
    checks++;
    if ({tap_EN, tap_WE, arbit_wready} !== '0) begin
      failures++;
      $display("FAIL rst_wr_pulse got en=%0b WE=%h wready=%0b required 0", tap_EN, tap_WE, arbit_wready);
    end
    step();
    areset = 0;
    clear_inputs();
    sample();
    checks++;
    if ({arbit_arready, arbit_awready, arbit_wready, arbit_rvalid, eng_gnt, eng_rvalid,
         tap_EN, tap_WE, tap_A, tap_Di, slv_Do} !== '0) begin
      failures++;
      $display("FAIL rst_wr_outputs got wready=%0b rvalid=%0b en=%0b WE=%h slv_Do=%h required all 0",
               arbit_wready, arbit_rvalid, tap_EN, tap_WE, slv_Do);
    end
    step();
    s_arvalid = 1; slv_A = 5; slv_EN = 1;
    sample();
    checks++;
    if (arbit_arready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wr_idle got arready=%0b required 1", arbit_arready);
    end
    step();
    s_arvalid = 0;
    rd_data_phase(v, got);
    checks++;
    if (v !== 1'b1 || got !== shadow[5]) begin
      failures++;
      $display("FAIL rst_wr_nowrite got rvalid=%0b data=%h required 1 %h", v, got, shadow[5]);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_random();
    int             rd_st, wr_st, rd_cyc, ar_wait;
    logic           last_write, eng_pend, idle, eng_wins, exp_ar, exp_aw, exp_gnt, whsk, exp_en;
    logic [AW-1:0]  rd_addr, wr_addr;
    logic [DW-1:0]  wr_data, rd_exp, eng_pend_data;
    logic [WEW-1:0] wr_mask, exp_we;
    logic [6:0]     exp_ctrl, got_ctrl;
    areset = 1;
    step();
    areset = 0;
    rd_st = 0; wr_st = 0; rd_cyc = 0; ar_wait = 0; last_write = 0; eng_pend = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0; rd_exp = '0; eng_pend_data = '0;
    for (int c = 0; c < 1500; c++) begin
      if (rd_st == 0 && $urandom_range(0, 99) < 30) begin
        rd_st = 1; rd_addr = AW'($urandom_range(0, 15));
      end
      if (wr_st == 0 && $urandom_range(0, 99) < 30) begin
        wr_st = 1; wr_addr = AW'($urandom_range(0, 15)); wr_data = $urandom;
        wr_mask = WEW'($urandom_range(1, (1 << WEW) - 1));
      end
      if ($urandom_range(0, 15) == 0) engine_busy = !engine_busy;
      eng_req   = ($urandom_range(0, 99) < 60);
      eng_A     = AW'($urandom_range(0, 15));
      s_arvalid = (rd_st == 1);
      s_awvalid = (wr_st == 1);
      s_wvalid  = (wr_st == 2) && ($urandom_range(0, 99) < 70);
      s_rready  = (rd_st == 2) && ($urandom_range(0, 99) < 60);
      slv_A     = (wr_st == 2) ? wr_addr : rd_addr;
      slv_EN    = (rd_st != 0) || s_wvalid;
      slv_WE    = s_wvalid ? wr_mask : '0;
      slv_Di    = wr_data;
      sample();

      idle     = (rd_st != 2) && (wr_st != 2);
      eng_wins = eng_req && !(s_arvalid && ar_wait == SL);
      exp_ar   = idle && !eng_wins && s_arvalid && (!(s_awvalid && !engine_busy) || last_write);
      exp_aw   = idle && !eng_wins && s_awvalid && !engine_busy && !exp_ar;
      exp_gnt  = idle ? eng_wins : (rd_st == 2) ? eng_req : 1'b0;
      whsk     = (wr_st == 2) && s_wvalid;
      exp_en   = exp_gnt || exp_ar || whsk;
      exp_we   = whsk ? wr_mask : '0;
      exp_ctrl = {exp_ar, exp_aw, wr_st == 2, rd_st == 2 && rd_cyc > 0, exp_gnt, eng_pend, exp_en};
      got_ctrl = {arbit_arready, arbit_awready, arbit_wready, arbit_rvalid, eng_gnt, eng_rvalid, tap_EN};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL rnd_ctrl c=%0d got ar,aw,w,rv,gnt,erv,en=%b required %b", c, got_ctrl, exp_ctrl);
      end
      checks++;
      if (tap_WE !== exp_we) begin
        failures++;
        $display("FAIL rnd_we c=%0d got %h required %h", c, tap_WE, exp_we);
      end
      if (exp_en) begin
        checks++;
        if (tap_A !== (exp_gnt ? eng_A : slv_A) || (whsk && tap_Di !== wr_data)) begin
          failures++;
          $display("FAIL rnd_port c=%0d got A=%0d Di=%h required A=%0d Di=%h", c, tap_A, tap_Di,
                   exp_gnt ? eng_A : slv_A, wr_data);
        end
      end
      if (rd_st == 2 && rd_cyc > 0) begin
        checks++;
        if (slv_Do !== rd_exp) begin
          failures++;
          $display("FAIL rnd_rdata c=%0d got %h required %h", c, slv_Do, rd_exp);
        end
      end
      if (eng_pend) begin
        checks++;
        if (eng_Do !== eng_pend_data) begin
          failures++;
          $display("FAIL rnd_eng_data c=%0d got %h required %h", c, eng_Do, eng_pend_data);
        end
      end

      if (!s_arvalid || exp_ar) ar_wait = 0;
      else if (idle && ar_wait < SL) ar_wait++;
      eng_pend = exp_gnt;
      eng_pend_data = shadow[eng_A];
      if (rd_st == 2) begin
        if (rd_cyc > 0 && s_rready) rd_st = 0;
        rd_cyc++;
      end
      if (exp_ar) begin
        rd_st = 2; rd_cyc = 0; rd_exp = shadow[rd_addr]; last_write = 0;
      end
      if (whsk) begin
        for (int b = 0; b < WEW; b++)
          if (wr_mask[b]) shadow[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        wr_st = 0;
      end
      if (exp_aw) begin
        wr_st = 2; last_write = 1;
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    clear_inputs();
    areset = 1;
    step();
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_starve();
    test_aw_blocked();
    test_reset_in_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
